// File: rtl/bomb_alarm_display.sv
// bomb_alarm_display
//   Alarm front-end for the countdown timer. Shows the count on an active-low
//   seven-segment digit, blinks a warning near zero, sounds a buzzer burst on
//   detonation and latches the detonated state until the operator clears it.
//   Every output is registered and updates one cycle after its cause.
//
// Optional feature: define BOMB_ALARM_DECIMAL_EN to show the count in decimal
//   (units on Seg, tens on the extra Seg_Tens output).
//
// Ports:
//   Clock       in   system clock, rising edge
//   Reset       in   synchronous, active-high reset
//   Count_In    in   [3:0] countdown value
//   Blow_Up_In  in   detonation request, sampled every cycle
//   Clear       in   operator acknowledge, leaves BOOM/HOLD
//   Seg         out  [6:0] {g,f,e,d,c,b,a}, active-low
//   Seg_Tens    out  [6:0] tens digit, active-low (BOMB_ALARM_DECIMAL_EN only)
//   Alarm_LED   out  warning/detonation lamp
//   Buzzer      out  buzzer drive
//   Detonated   out  high in BOOM and HOLD
module bomb_alarm_display #(
    parameter int unsigned WARN_LEVEL  = 3,
    parameter int unsigned BLINK_DIV   = 4,
    parameter int unsigned BUZZ_PULSES = 8,
    parameter int unsigned BUZZ_PERIOD = 2
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [3:0] Count_In,
    input  logic       Blow_Up_In,
    input  logic       Clear,
    output logic [6:0] Seg,
`ifdef BOMB_ALARM_DECIMAL_EN
    output logic [6:0] Seg_Tens,
`endif
    output logic       Alarm_LED,
    output logic       Buzzer,
    output logic       Detonated
);

    localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int PHASE_W = (BUZZ_PERIOD > 1) ? $clog2(BUZZ_PERIOD) : 1;
    localparam int PULSE_W = $clog2(BUZZ_PULSES + 1);

    localparam logic [3:0]         WARN_LVL    = 4'(WARN_LEVEL);
    localparam logic [BLINK_W-1:0] BLINK_LAST  = BLINK_W'(BLINK_DIV - 1);
    localparam logic [PHASE_W-1:0] PHASE_LAST  = PHASE_W'(BUZZ_PERIOD - 1);
    localparam logic [PULSE_W-1:0] PULSE_LAST  = PULSE_W'(BUZZ_PULSES - 1);

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    typedef enum logic [1:0] {
        StNormal,
        StWarn,
        StBoom,
        StHold
    } state_e;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0:    s = 7'h40;
            4'h1:    s = 7'h79;
            4'h2:    s = 7'h24;
            4'h3:    s = 7'h30;
            4'h4:    s = 7'h19;
            4'h5:    s = 7'h12;
            4'h6:    s = 7'h02;
            4'h7:    s = 7'h78;
            4'h8:    s = 7'h00;
            4'h9:    s = 7'h10;
            4'hA:    s = 7'h08;
            4'hB:    s = 7'h03;
            4'hC:    s = 7'h46;
            4'hD:    s = 7'h21;
            4'hE:    s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    state_e             r_state;
    logic [BLINK_W-1:0] r_blink_cnt;
    logic               r_blink_phase;
    logic [PHASE_W-1:0] r_buzz_phase_cnt;
    logic               r_buzz_level;
    logic [PULSE_W-1:0] r_pulse_cnt;
    logic [6:0]         r_seg;
    logic               r_led;
    logic               r_buzz;
    logic               r_det;

    state_e             w_state_d;
    logic [BLINK_W-1:0] w_blink_cnt_d;
    logic               w_blink_phase_d;
    logic [PHASE_W-1:0] w_buzz_phase_cnt_d;
    logic               w_buzz_level_d;
    logic [PULSE_W-1:0] w_pulse_cnt_d;
    logic [6:0]         w_seg_d;
    logic               w_led_d;
    logic               w_buzz_d;
    logic               w_det_d;
    logic               w_in_warn_range;
    logic               w_burst_done;
    logic [6:0]         w_digit;

`ifdef BOMB_ALARM_DECIMAL_EN
    logic [6:0] r_seg_tens;
    logic [6:0] w_seg_tens_d;
    logic [6:0] w_tens;
    logic       w_ge_ten;

    assign w_ge_ten = (Count_In >= 4'd10);
    assign w_digit  = hex7(w_ge_ten ? (Count_In - 4'd10) : Count_In);
    assign w_tens   = w_ge_ten ? 7'h79 : SEG_BLANK;
    assign Seg_Tens = r_seg_tens;
`else
    assign w_digit  = hex7(Count_In);
`endif

    assign w_in_warn_range = (Count_In != 4'd0) && (Count_In <= WARN_LVL);

    // Last cycle of the low half of the final pulse ends the burst.
    assign w_burst_done = (r_state == StBoom) && (r_buzz_phase_cnt == PHASE_LAST) &&
                          !r_buzz_level && (r_pulse_cnt == PULSE_LAST);

    always_comb begin
        w_state_d          = r_state;
        w_blink_cnt_d      = '0;
        w_blink_phase_d    = 1'b0;
        w_buzz_phase_cnt_d = '0;
        w_buzz_level_d     = 1'b0;
        w_pulse_cnt_d      = '0;
        w_seg_d            = SEG_BLANK;
        w_led_d            = 1'b0;
        w_buzz_d           = 1'b0;
        w_det_d            = 1'b0;
`ifdef BOMB_ALARM_DECIMAL_EN
        w_seg_tens_d       = SEG_BLANK;
`endif

        unique case (r_state)
            StNormal, StWarn: begin
                if (Blow_Up_In) begin
                    w_state_d = StBoom;
                end else if (w_in_warn_range) begin
                    w_state_d = StWarn;
                end else begin
                    w_state_d = StNormal;
                end
            end
            StBoom: begin
                if (Clear) begin
                    w_state_d = StNormal;
                end else if (w_burst_done) begin
                    w_state_d = StHold;
                end
            end
            StHold: begin
                if (Clear) begin
                    w_state_d = StNormal;
                end
            end
            default: w_state_d = StNormal;
        endcase

        // Blink counter runs only while staying in WARN; entry restarts at phase 1.
        if (w_state_d == StWarn) begin
            if (r_state != StWarn) begin
                w_blink_cnt_d   = '0;
                w_blink_phase_d = 1'b1;
            end else if (r_blink_cnt == BLINK_LAST) begin
                w_blink_cnt_d   = '0;
                w_blink_phase_d = ~r_blink_phase;
            end else begin
                w_blink_cnt_d   = r_blink_cnt + 1'b1;
                w_blink_phase_d = r_blink_phase;
            end
        end

        // Buzz counters: phase within a half-period, level, completed pulses.
        if (w_state_d == StBoom) begin
            if (r_state != StBoom) begin
                w_buzz_phase_cnt_d = '0;
                w_buzz_level_d     = 1'b1;
                w_pulse_cnt_d      = '0;
            end else if (r_buzz_phase_cnt == PHASE_LAST) begin
                w_buzz_phase_cnt_d = '0;
                w_buzz_level_d     = ~r_buzz_level;
                w_pulse_cnt_d      = r_buzz_level ? r_pulse_cnt : r_pulse_cnt + 1'b1;
            end else begin
                w_buzz_phase_cnt_d = r_buzz_phase_cnt + 1'b1;
                w_buzz_level_d     = r_buzz_level;
                w_pulse_cnt_d      = r_pulse_cnt;
            end
        end

        unique case (w_state_d)
            StNormal: begin
                w_seg_d = w_digit;
`ifdef BOMB_ALARM_DECIMAL_EN
                w_seg_tens_d = w_tens;
`endif
            end
            StWarn: begin
                w_led_d = w_blink_phase_d;
                w_seg_d = w_blink_phase_d ? w_digit : SEG_BLANK;
`ifdef BOMB_ALARM_DECIMAL_EN
                w_seg_tens_d = w_blink_phase_d ? w_tens : SEG_BLANK;
`endif
            end
            StBoom: begin
                w_seg_d  = SEG_DASH;
                w_led_d  = 1'b1;
                w_det_d  = 1'b1;
                w_buzz_d = w_buzz_level_d;
`ifdef BOMB_ALARM_DECIMAL_EN
                w_seg_tens_d = SEG_DASH;
`endif
            end
            default: begin
                w_seg_d = SEG_DASH;
                w_led_d = 1'b1;
                w_det_d = 1'b1;
`ifdef BOMB_ALARM_DECIMAL_EN
                w_seg_tens_d = SEG_DASH;
`endif
            end
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state          <= StNormal;
            r_blink_cnt      <= '0;
            r_blink_phase    <= 1'b0;
            r_buzz_phase_cnt <= '0;
            r_buzz_level     <= 1'b0;
            r_pulse_cnt      <= '0;
            r_seg            <= SEG_BLANK;
            r_led            <= 1'b0;
            r_buzz           <= 1'b0;
            r_det            <= 1'b0;
`ifdef BOMB_ALARM_DECIMAL_EN
            r_seg_tens       <= SEG_BLANK;
`endif
        end else begin
            r_state          <= w_state_d;
            r_blink_cnt      <= w_blink_cnt_d;
            r_blink_phase    <= w_blink_phase_d;
            r_buzz_phase_cnt <= w_buzz_phase_cnt_d;
            r_buzz_level     <= w_buzz_level_d;
            r_pulse_cnt      <= w_pulse_cnt_d;
            r_seg            <= w_seg_d;
            r_led            <= w_led_d;
            r_buzz           <= w_buzz_d;
            r_det            <= w_det_d;
`ifdef BOMB_ALARM_DECIMAL_EN
            r_seg_tens       <= w_seg_tens_d;
`endif
        end
    end

    assign Seg       = r_seg;
    assign Alarm_LED = r_led;
    assign Buzzer    = r_buzz;
    assign Detonated = r_det;

endmodule

// File: doc/bomb_alarm_display.md
Name: bomb_alarm_display

Overview:
- Downstream consumer of the countdown timer; takes its 4-bit count and one-cycle blow-up pulse.
- Drives a registered, active-low seven-segment digit.
- Runs an alarm state machine: steady display, blinking warning near zero, a buzzer burst on detonation, then a latched detonated state until cleared.
- Sits between the timer and the board LEDs, buzzer and segment pins.

Parameters:
- WARN_LEVEL, 3: counts at or below this value (and non-zero) select the warning state.
- BLINK_DIV, 4: warning half-period, in clock cycles.
- BUZZ_PULSES, 8: number of Buzzer high pulses per detonation burst.
- BUZZ_PERIOD, 2: cycles Buzzer stays high, and then low, per pulse.

Ports:
- Clock  input  1  system clock; all logic on rising edge.
- Reset  input  1  synchronous, active-high reset.
- Count_In  input  4  countdown value from the timer.
- Blow_Up_In  input  1  detonation pulse from the timer; level-sensitive, sampled each cycle.
- Clear  input  1  operator acknowledge; leaves the detonated states.
- Seg  output  7  segment drive {g,f,e,d,c,b,a}, active-low.
- Alarm_LED  output  1  warning/detonation lamp.
- Buzzer  output  1  buzzer drive.
- Detonated  output  1  high from BOOM entry until Clear or Reset.

Behaviour:
- Interface: one clock; reset is synchronous and active-high (ports Clock and Reset).
- Reset values:
  - Seg = 7'h7F (blank); Alarm_LED, Buzzer and Detonated all 0.
  - State = NORMAL; blink and buzz counters cleared.
- Registered outputs: every output updates one cycle after the inputs that cause it.
- Hex decode (active-low): 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E. Dash = 3F.
- States:
  - NORMAL:
    - Seg = hex(Count_In); Alarm_LED = 0; Buzzer = 0.
    - Goes to WARN when 0 < Count_In <= WARN_LEVEL.
  - WARN:
    - On entry the blink counter clears and the blink phase is 1.
    - The phase toggles every BLINK_DIV cycles.
    - Alarm_LED = phase; Seg = hex(Count_In) when phase is 1, else 7F.
    - Returns to NORMAL if Count_In > WARN_LEVEL or Count_In == 0, e.g. timer reset to 15.
  - BOOM:
    - Entered from NORMAL or WARN whenever Blow_Up_In = 1; this has priority over the count-based transitions.
    - Detonated = 1; Alarm_LED = 1; Seg = 3F.
    - Buzzer starts high on the first BOOM cycle and toggles every BUZZ_PERIOD cycles.
    - After the BUZZ_PULSES-th high pulse completes, go to HOLD; the burst lasts 2*BUZZ_PULSES*BUZZ_PERIOD cycles.
  - HOLD: Buzzer = 0; Detonated = 1; Alarm_LED = 1; Seg = 3F.
- Clear:
  - In BOOM or HOLD: go to NORMAL next cycle, which clears Detonated and Buzzer and stops the burst mid-stream.
  - In NORMAL or WARN: no effect.
- Blow_Up_In while in BOOM or HOLD is ignored; the burst does not restart.
- Blow_Up_In and Clear asserted together in HOLD: Clear wins, go to NORMAL. Blow_Up_In is then evaluated again on the following cycle.
- Count_In == 0 without Blow_Up_In: stay in or go to NORMAL and display 0. The timer raises blow-up one cycle later.
- Count wrapping from 0 to F while in BOOM or HOLD: display unaffected.
- Reset mid-burst: all outputs return to their reset values next cycle.
- Counter widths: the blink counter is sized for BLINK_DIV-1. The buzz pulse counter is sized for BUZZ_PULSES, with a phase counter sized for BUZZ_PERIOD-1. None of these wrap outside their own state.

Optional Feature:
- Macro: BOMB_ALARM_DECIMAL_EN.
- Defined:
  - Adds output Seg_Tens [6:0], active-low.
  - Count_In is shown in decimal: Seg = units digit; Seg_Tens = "1" (79) for 10-15, blank (7F) for 0-9.
  - Seg_Tens follows the same blink/dash/reset rules as Seg: 7F on reset, 3F in BOOM/HOLD.
- Undefined: no Seg_Tens port; Seg shows the hex digit.

Test Plan:
- Reset high 2 cycles -> Seg=7F, Alarm_LED=0, Buzzer=0, Detonated=0.
- Count_In=9, then 4 -> Seg=10, then Seg=19 one cycle after each change; Alarm_LED=0 throughout.
- Count_In=3 held, default params -> Alarm_LED pattern 1111 0000 1111; Seg alternates 30/7F in step with Alarm_LED.
- Blow_Up_In pulse in WARN -> next cycle Detonated=1, Seg=3F. Buzzer shows 8 pulses of 2 high/2 low (32 cycles), then stays 0 with Detonated still 1.
- Clear at cycle 10 of the burst -> next cycle Buzzer=0, Detonated=0, NORMAL. A Blow_Up_In pulse with Clear in HOLD -> NORMAL, no new burst.
- Macro defined, Count_In=12 -> Seg_Tens=79, Seg=24. Count_In=7 -> Seg_Tens=7F, Seg=78.
